// File: rtl/otter_mem_arbiter.sv
// Arbitrates the OTTER unified memory between the fetch port and the MEM-stage data port.
// Data normally wins; a streak counter guarantees fetch progress under sustained data traffic.
module otter_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LAT     = 2,
  parameter int MAX_DSTREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int LAT_W = $clog2(MEM_LAT) + 1;
  localparam int STK_W = $clog2(MAX_DSTREAK + 1);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  state_t           state;
  owner_t           owner;
  logic             is_write;
  logic [LAT_W-1:0] lat_cnt;
  logic [STK_W-1:0] streak;

  logic done;
  logic can_grant;
  logic sel_d;
  logic sel_if;

  // The completion cycle doubles as a grant slot, giving one transaction every MEM_LAT cycles.
  assign done      = (state == BUSY) && (lat_cnt == LAT_W'(MEM_LAT - 1));
  assign can_grant = !rst && ((state == IDLE) || done);
  assign sel_d     = can_grant && d_req && (!if_req || (streak != STK_W'(MAX_DSTREAK)));
  assign sel_if    = can_grant && if_req && !sel_d;

  assign if_gnt = sel_if;
  assign d_gnt  = sel_d;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (sel_d) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (sel_if) begin
      mem_en    = 1'b1;
      mem_be    = {BE_W{1'b1}};
      mem_addr  = if_addr;
    end
  end

  // Read data is forwarded straight from the memory in the completion cycle; writes ack with zero.
  assign if_rvalid = done && (owner == OWN_IF);
  assign d_rvalid  = done && (owner == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = (d_rvalid && !is_write) ? mem_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= OWN_IF;
      is_write <= 1'b0;
      lat_cnt  <= '0;
      streak   <= '0;
    end else begin
      if (sel_d || sel_if) begin
        state    <= BUSY;
        lat_cnt  <= '0;
        owner    <= sel_d ? OWN_D : OWN_IF;
        is_write <= sel_d && d_we;
      end else if (done) begin
        state   <= IDLE;
        lat_cnt <= '0;
      end else if (state == BUSY) begin
        lat_cnt <= lat_cnt + LAT_W'(1);
      end

      // Streak counts data wins that made a waiting fetch stand aside.
      if (sel_if) begin
        streak <= '0;
      end else if (sel_d) begin
        if (!if_req)
          streak <= '0;
        else if (streak != STK_W'(MAX_DSTREAK))
          streak <= streak + STK_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Scoreboard bench for otter_mem_arbiter: MEM_LAT=2 instance for most scenarios, MEM_LAT=1 for back-to-back fetch.
module tb_otter_mem_arbiter;

  typedef struct packed {
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct packed {
    int          cyc;
    logic [31:0] data;
  } rv_t;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;

  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        if_req1;
  logic [31:0] if_addr1;
  logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1;
  logic [31:0] if_rdata1, d_rdata1;
  logic        mem_en1, mem_we1;
  logic [3:0]  mem_be1;
  logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;

  logic [31:0] p0, p1, p0b;

  gnt_t qIfGnt[$], qDGnt[$], qIfGnt1[$];
  rv_t  qIfRv[$], qDRv[$], qIfRv1[$];
  gnt_t gm, gm1;
  rv_t  rm, rm1;

  otter_mem_arbiter #(.MEM_LAT(2), .MAX_DSTREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  otter_mem_arbiter #(.MEM_LAT(1), .MAX_DSTREAK(4)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .d_req(1'b0), .d_we(1'b0), .d_be(4'h0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_be(mem_be1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: 0x100 holds 0xDEADBEEF, every other word holds ~addr; non-access cycles return junk.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ~a;
  endfunction

  always @(posedge clk) begin
    p0  <= mem_en  ? memf(mem_addr)  : 32'h0BADF00D;
    p1  <= p0;
    p0b <= mem_en1 ? memf(mem_addr1) : 32'h0BADF00D;
  end
  assign mem_rdata  = p1;
  assign mem_rdata1 = p0b;

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitCycle(input int n);
    while (cyc < n) tick();
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                               input logic [3:0] db, input logic [31:0] da, input logic [31:0] dd);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dw;
    d_be    = db;
    d_addr  = da;
    d_wdata = dd;
  endtask

  task automatic expectIfGnt(input int c, input logic [31:0] a);
    qIfGnt.push_back('{cyc: c, addr: a, we: 1'b0, be: 4'hF, wdata: 32'h0});
  endtask

  task automatic expectDGnt(input int c, input logic [31:0] a, input logic w, input logic [3:0] b,
                            input logic [31:0] wd);
    qDGnt.push_back('{cyc: c, addr: a, we: w, be: b, wdata: wd});
  endtask

  task automatic expectIfRv(input int c, input logic [31:0] d);
    qIfRv.push_back('{cyc: c, data: d});
  endtask

  task automatic expectDRv(input int c, input logic [31:0] d);
    qDRv.push_back('{cyc: c, data: d});
  endtask

  // Monitor for the MEM_LAT=2 instance: every gnt/rvalid pops its queue; idle outputs must read zero.
  always @(negedge clk) begin
    if (rst)
      checkOutput("reset outputs", {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                                    mem_en, mem_we, mem_be, mem_addr, mem_wdata}, 160'd0);
    if (if_gnt && d_gnt) checkOutput("dual grant", 160'({if_gnt, d_gnt}), 160'd0);
    if (if_gnt) begin
      if (qIfGnt.size() == 0) checkOutput("if_gnt unexpected", 160'(if_gnt), 160'd0);
      else begin
        gm = qIfGnt.pop_front();
        checkOutput("if_gnt cycle", 160'(cyc), 160'(gm.cyc));
        checkOutput("if_gnt mem", {mem_en, mem_we, mem_be, mem_addr, mem_wdata},
                    {1'b1, gm.we, gm.be, gm.addr, gm.wdata});
      end
    end
    if (d_gnt) begin
      if (qDGnt.size() == 0) checkOutput("d_gnt unexpected", 160'(d_gnt), 160'd0);
      else begin
        gm = qDGnt.pop_front();
        checkOutput("d_gnt cycle", 160'(cyc), 160'(gm.cyc));
        checkOutput("d_gnt mem", {mem_en, mem_we, mem_be, mem_addr, mem_wdata},
                    {1'b1, gm.we, gm.be, gm.addr, gm.wdata});
      end
    end
    if (if_rvalid) begin
      if (qIfRv.size() == 0) checkOutput("if_rvalid unexpected", 160'(if_rvalid), 160'd0);
      else begin
        rm = qIfRv.pop_front();
        checkOutput("if_rvalid cycle", 160'(cyc), 160'(rm.cyc));
        checkOutput("if_rdata", 160'(if_rdata), 160'(rm.data));
      end
    end else checkOutput("if_rdata idle", 160'(if_rdata), 160'd0);
    if (d_rvalid) begin
      if (qDRv.size() == 0) checkOutput("d_rvalid unexpected", 160'(d_rvalid), 160'd0);
      else begin
        rm = qDRv.pop_front();
        checkOutput("d_rvalid cycle", 160'(cyc), 160'(rm.cyc));
        checkOutput("d_rdata", 160'(d_rdata), 160'(rm.data));
      end
    end else checkOutput("d_rdata idle", 160'(d_rdata), 160'd0);
    if (!if_gnt && !d_gnt)
      checkOutput("mem idle", {mem_en, mem_we, mem_be, mem_addr, mem_wdata}, 160'd0);
  end

  // Monitor for the MEM_LAT=1 instance, which only ever sees fetch traffic.
  always @(negedge clk) begin
    if (d_gnt1 || d_rvalid1) checkOutput("dut1 data unexpected", 160'({d_gnt1, d_rvalid1}), 160'd0);
    if (if_gnt1) begin
      if (qIfGnt1.size() == 0) checkOutput("dut1 if_gnt unexpected", 160'(if_gnt1), 160'd0);
      else begin
        gm1 = qIfGnt1.pop_front();
        checkOutput("dut1 if_gnt cycle", 160'(cyc), 160'(gm1.cyc));
        checkOutput("dut1 if_gnt mem", {mem_en1, mem_we1, mem_be1, mem_addr1, mem_wdata1},
                    {1'b1, gm1.we, gm1.be, gm1.addr, gm1.wdata});
      end
    end
    if (if_rvalid1) begin
      if (qIfRv1.size() == 0) checkOutput("dut1 if_rvalid unexpected", 160'(if_rvalid1), 160'd0);
      else begin
        rm1 = qIfRv1.pop_front();
        checkOutput("dut1 if_rvalid cycle", 160'(cyc), 160'(rm1.cyc));
        checkOutput("dut1 if_rdata", 160'(if_rdata1), 160'(rm1.data));
      end
    end else checkOutput("dut1 if_rdata idle", 160'(if_rdata1), 160'd0);
  end

  initial begin
    cyc      = 0;
    errors   = 0;
    checks   = 0;
    rst      = 1'b1;
    if_req1  = 1'b0;
    if_addr1 = 32'h0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    waitCycle(2);
    rst = 1'b0;

    // Single fetch read
    waitCycle(5);
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    expectIfGnt(5, 32'h100);
    expectIfRv(7, 32'hDEADBEEF);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Data write: acked with zero data even though the memory returns junk
    waitCycle(8);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h2000, 32'h1234ABCD);
    expectDGnt(8, 32'h2000, 1'b1, 4'b0011, 32'h1234ABCD);
    expectDRv(10, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Simultaneous: data first, fetch granted in the data completion cycle
    waitCycle(12);
    applyStimulus(1'b1, 32'h104, 1'b1, 1'b0, 4'hF, 32'h3000, 32'h11111111);
    expectDGnt(12, 32'h3000, 1'b0, 4'hF, 32'h11111111);
    expectDRv(14, 32'hFFFFCFFF);
    expectIfGnt(14, 32'h104);
    expectIfRv(16, 32'hFFFFFEFB);
    tick();
    applyStimulus(1'b1, 32'h104, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    waitCycle(15);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Starvation guard: four data wins, then fetch, then data again
    waitCycle(18);
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 4'hF, 32'h4000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      expectDGnt(18 + 2 * i, 32'h4000, 1'b0, 4'hF, 32'h0);
      expectDRv(20 + 2 * i, 32'hFFFFBFFF);
    end
    expectIfGnt(26, 32'h200);
    expectIfRv(28, 32'hFFFFFDFF);
    expectDGnt(28, 32'h4000, 1'b0, 4'hF, 32'h0);
    expectDRv(30, 32'hFFFFBFFF);
    waitCycle(29);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // MEM_LAT=1 back-to-back fetches
    waitCycle(33);
    for (int i = 0; i < 3; i++) begin
      if_req1  = 1'b1;
      if_addr1 = 32'(4 * i);
      qIfGnt1.push_back('{cyc: 33 + i, addr: 32'(4 * i), we: 1'b0, be: 4'hF, wdata: 32'h0});
      qIfRv1.push_back('{cyc: 34 + i, data: ~(32'(4 * i))});
      tick();
    end
    if_req1  = 1'b0;
    if_addr1 = 32'h0;

    // Reset one cycle after a data read grant: the read is dropped, the next request wins at once
    waitCycle(40);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h3000, 32'h0);
    expectDGnt(40, 32'h3000, 1'b0, 4'hF, 32'h0);
    tick();
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h3004, 32'h0);
    #1;
    checkOutput("reset immediate", {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                                    mem_en, mem_we, mem_be, mem_addr, mem_wdata}, 160'd0);
    waitCycle(43);
    rst = 1'b0;
    expectDGnt(43, 32'h3004, 1'b0, 4'hF, 32'h0);
    expectDRv(45, 32'hFFFFCFFB);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    waitCycle(50);
    checkOutput("if_gnt missing",       160'(qIfGnt.size()),  160'd0);
    checkOutput("d_gnt missing",        160'(qDGnt.size()),   160'd0);
    checkOutput("if_rvalid missing",    160'(qIfRv.size()),   160'd0);
    checkOutput("d_rvalid missing",     160'(qDRv.size()),    160'd0);
    checkOutput("dut1 if_gnt missing",  160'(qIfGnt1.size()), 160'd0);
    checkOutput("dut1 if_rvalid missing", 160'(qIfRv1.size()), 160'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
